ahb_master_if: RTL and testbench

Bus-master interface engine that sits between a local command source and the shared AHB fabric, on the requesting side of the bus arbiter. It accepts one single-beat read or write command at a time, raises `hreq` toward the arbiter, waits for `hgrant`, and runs one NONSEQ address phase and one data phase against the selected slave. It then returns read data or error status to the command source and releases the request.

---
 rtl/ahb_master_if.sv | 192 +++++++++++++++++++
 tb/tb_ahb_master_if.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_if.sv
// ahb_master_if: single-beat AHB bus master engine.
// Takes one read/write command at a time from a local source, requests the bus,
// runs one NONSEQ address phase plus one data phase, and returns a response pulse.
// Optional feature macro: AHB_MASTER_RETRY_EN. When defined, ERROR responses are
// reissued up to MAX_RETRY times before completing with rsp_err.
module ahb_master_if #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_RETRY = 3
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_sel,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              hreq,
    input  logic              hgrant,
    output logic [1:0]        sel,
    output logic [ADDR_W-1:0] haddr,
    output logic              hwrite,
    output logic [1:0]        htrans,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready_out,
    input  logic              hresp,
    input  logic [DATA_W-1:0] hrdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StAddr = 2'd2;
    localparam logic [1:0] StData = 2'd3;

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransNonseq = 2'b10;

    logic [1:0]        state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              hreq_d;
    logic [1:0]        sel_d;
    logic [ADDR_W-1:0] haddr_d;
    logic              hwrite_d;
    logic [1:0]        htrans_d;
    logic [DATA_W-1:0] hwdata_d;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              rsp_err_d;
    logic              can_retry;

`ifdef AHB_MASTER_RETRY_EN
    // Counter wide enough to hold MAX_RETRY, never zero width.
    localparam int RCNT_W = $clog2(MAX_RETRY + 2);
    localparam logic [RCNT_W-1:0] RetryLimit = RCNT_W'(MAX_RETRY);

    logic [RCNT_W-1:0] retry_q, retry_d;

    assign can_retry = (retry_q < RetryLimit);
`else
    assign can_retry = 1'b0;
`endif

    // Commands are only taken while the engine is idle.
    assign cmd_ready = (state_q == StIdle);

    // Next-state and next-output decode for the transfer sequence.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        hreq_d      = hreq;
        sel_d       = sel;
        haddr_d     = haddr;
        hwrite_d    = hwrite;
        htrans_d    = htrans;
        hwdata_d    = hwdata;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
`ifdef AHB_MASTER_RETRY_EN
        retry_d     = retry_q;
`endif
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d = StReq;
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    hreq_d  = 1'b1;
                    sel_d   = cmd_sel;
`ifdef AHB_MASTER_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            StReq: begin
                if (hgrant) begin
                    state_d  = StAddr;
                    haddr_d  = addr_q;
                    hwrite_d = write_q;
                    htrans_d = HtransNonseq;
                end
            end
            StAddr: begin
                // Address phase lasts exactly one cycle; write data follows.
                state_d  = StData;
                haddr_d  = '0;
                hwrite_d = 1'b0;
                htrans_d = HtransIdle;
                hwdata_d = write_q ? wdata_q : '0;
            end
            StData: begin
                if (hready_out) begin
                    if (!hresp) begin
                        state_d     = StIdle;
                        hreq_d      = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = write_q ? '0 : hrdata;
                    end else if (can_retry) begin
                        // Keep hreq high and go back to reissue the same command.
                        state_d = StReq;
`ifdef AHB_MASTER_RETRY_EN
                        retry_d = retry_q + 1'b1;
`endif
                    end else begin
                        state_d     = StIdle;
                        hreq_d      = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, captured command and registered bus/response outputs.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q   <= StIdle;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            hreq      <= 1'b0;
            sel       <= 2'b00;
            haddr     <= '0;
            hwrite    <= 1'b0;
            htrans    <= HtransIdle;
            hwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            hreq      <= hreq_d;
            sel       <= sel_d;
            haddr     <= haddr_d;
            hwrite    <= hwrite_d;
            htrans    <= htrans_d;
            hwdata    <= hwdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

`ifdef AHB_MASTER_RETRY_EN
    // Reissue counter, cleared on every accepted command.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

endmodule

// File: tb/tb_ahb_master_if.sv
// tb_ahb_master_if: randomized bench with a transaction-level latency/response model.
// Acts as arbiter (registered grant, optional extra delay) and slave (wait states,
// ERROR responses) and predicts each command's outcome from the protocol rules.
module tb_ahb_master_if;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MR = 3;

    logic          hclk = 1'b0;
    logic          hreset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [1:0]    cmd_sel;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          hreq;
    logic          hgrant;
    logic [1:0]    sel;
    logic [AW-1:0] haddr;
    logic          hwrite;
    logic [1:0]    htrans;
    logic [DW-1:0] hwdata;
    logic          hready_out;
    logic          hresp;
    logic [DW-1:0] hrdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    int checks = 0;
    int errors = 0;

    ahb_master_if #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_RETRY (MR)
    ) dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_sel    (cmd_sel),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .hreq       (hreq),
        .hgrant     (hgrant),
        .sel        (sel),
        .haddr      (haddr),
        .hwrite     (hwrite),
        .htrans     (htrans),
        .hwdata     (hwdata),
        .hready_out (hready_out),
        .hresp      (hresp),
        .hrdata     (hrdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 hclk = ~hclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_hreq"}, hreq, 0);
        check_eq({tag, "_sel"}, sel, 0);
        check_eq({tag, "_haddr"}, haddr, 0);
        check_eq({tag, "_hwrite"}, hwrite, 0);
        check_eq({tag, "_htrans"}, htrans, 0);
        check_eq({tag, "_hwdata"}, hwdata, 0);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        check_eq({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check_eq({tag, "_rsp_err"}, rsp_err, 0);
        check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    // Number of address phases a command gets when the first e attempts error.
    function automatic int attempts_for(input int e);
`ifdef AHB_MASTER_RETRY_EN
        return (e > MR) ? MR + 1 : e + 1;
`else
        return 1;
`endif
    endfunction

    // Run one command. g: extra grant delay, e: leading erroring attempts,
    // wfix: wait states per attempt (negative = random 0..3), rd: read data.
    task automatic run_cmd(input logic wr, input logic [1:0] s, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int g, input int e,
                           input int wfix, input logic [DW-1:0] rd);
        int att;
        logic exp_err;
        int w[16];
        int exp_lat;
        int lat;
        int nons;
        int idx;
        int wl;
        int bad_hold;
        int bad_trans;
        int bad_addr;
        int bad_wdata;
        logic enter;
        logic indata;
        logic done;

        att     = attempts_for(e);
        exp_err = (e >= att);
        // Registered grant costs one edge; each attempt is address + data entry
        // + completion plus its wait states.
        exp_lat = 1 + g;
        for (int i = 0; i < 16; i++) begin
            w[i] = (wfix >= 0) ? wfix : int'($urandom_range(0, 3));
            if (i < att) exp_lat += w[i] + 3;
        end

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_sel   = s;
        cmd_addr  = a;
        cmd_wdata = d;
        check_eq("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_write = ~wr;
        cmd_sel   = 2'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        check_eq("accept_hreq", hreq, 1);
        check_eq("accept_sel", sel, s);
        check_eq("accept_cmd_ready", cmd_ready, 0);
        check_eq("rsp_pulse", rsp_valid, 0);
        check_eq("accept_htrans", htrans, 0);

        lat = 0; nons = 0; wl = 0;
        bad_hold = 0; bad_trans = 0; bad_addr = 0; bad_wdata = 0;
        enter = 1'b0; indata = 1'b0; done = 1'b0;
        while (!done && lat < 300) begin
            tick();
            lat++;
            if (rsp_valid === 1'b1) begin
                done = 1'b1;
            end else begin
                if (hreq !== 1'b1 || cmd_ready !== 1'b0) bad_hold++;
                if (htrans === 2'b10) begin
                    nons++;
                    if (haddr !== a || hwrite !== wr) bad_addr++;
                    if (lat < 2 + g || enter) bad_trans++;
                    enter = 1'b1;
                end else if (htrans !== 2'b00) begin
                    bad_trans++;
                end else if (enter) begin
                    enter  = 1'b0;
                    indata = 1'b1;
                    idx    = (nons > 16) ? 15 : nons - 1;
                    wl     = w[idx];
                end
                if (indata) begin
                    if (wr && hwdata !== d) bad_wdata++;
                    if (wl > 0) begin
                        hready_out = 1'b0;
                        hresp      = 1'b0;
                        hrdata     = $urandom;
                        wl--;
                    end else begin
                        hready_out = 1'b1;
                        hresp      = (nons - 1 < e);
                        hrdata     = rd;
                        indata     = 1'b0;
                    end
                end else begin
                    hready_out = 1'b1;
                    hresp      = 1'b0;
                    hrdata     = $urandom;
                end
                if (lat == 1 + g) hgrant = 1'b1;
            end
        end
        hgrant     = 1'b0;
        hready_out = 1'b1;
        hresp      = 1'b0;
        hrdata     = $urandom;

        check_eq("rsp_seen", done, 1);
        check_eq("latency", lat, exp_lat);
        check_eq("nonseq_count", nons, att);
        check_eq("rsp_err", rsp_err, exp_err);
        if (!exp_err) check_eq("rsp_rdata", rsp_rdata, wr ? '0 : rd);
        check_eq("hreq_falls_with_rsp", hreq, 0);
        check_eq("hreq_cmd_ready_held", bad_hold, 0);
        check_eq("htrans_sequence", bad_trans, 0);
        check_eq("nonseq_addr_dir", bad_addr, 0);
        check_eq("hwdata_held", bad_wdata, 0);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq("idle_hreq", hreq, 0);
            check_eq("idle_cmd_ready", cmd_ready, 1);
        end
    endtask

    initial begin
        int seen;
        hreset     = 1'b1;
        cmd_valid  = 1'b1;
        cmd_write  = 1'b1;
        cmd_sel    = 2'd3;
        cmd_addr   = '1;
        cmd_wdata  = '1;
        hgrant     = 1'b0;
        hready_out = 1'b1;
        hresp      = 1'b0;
        hrdata     = '0;
        repeat (3) tick();
        check_reset("reset");
        cmd_valid = 1'b0;
        hreset    = 1'b0;
        idle_gap(1);

        run_cmd(1'b1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0, 32'h0);
        run_cmd(1'b0, 2'd1, 32'h0000_0020, 32'h0, 0, 0, 3, 32'h1234_5678);
        run_cmd(1'b0, 2'd0, 32'h0000_0040, 32'h0, 10, 0, 0, 32'hCAFE_F00D);
        idle_gap(2);
        run_cmd(1'b1, 2'd3, 32'h0000_0080, 32'h0BAD_CAFE, 0, 9, 0, 32'h0);
        run_cmd(1'b0, 2'd2, 32'h0000_0100, 32'h0, 1, 1, 1, 32'h55AA_33CC);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) idle_gap(int'($urandom_range(1, 3)));
            run_cmd(1'($urandom), 2'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 5)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0,
                    -1, $urandom);
        end

        // Reset while the data phase is stalled.
        cmd_valid  = 1'b1;
        cmd_write  = 1'b1;
        cmd_sel    = 2'd3;
        cmd_addr   = 32'hA5A5_0000;
        cmd_wdata  = 32'h5A5A_1234;
        hready_out = 1'b0;
        tick();
        cmd_valid = 1'b0;
        hgrant    = 1'b1;
        repeat (3) tick();
        check_eq("pre_reset_hwdata", hwdata, 32'h5A5A_1234);
        check_eq("pre_reset_hreq", hreq, 1);
        #2 hreset = 1'b1;
        #1;
        check_reset("mid_reset");
        @(posedge hclk);
        #1;
        hreset     = 1'b0;
        hgrant     = 1'b0;
        hready_out = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || hreq !== 1'b0) seen++;
        end
        check_eq("no_rsp_after_reset", seen, 0);
        run_cmd(1'b0, 2'd1, 32'h0000_0200, 32'h0, 0, 0, 0, 32'h0F0F_F0F0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
